zion_shift_req_stage: RTL

//  Request staging stage upstream of the multi-type combinational shifter.
//  - Accepts shift requests (opcode, data, amount) over a valid/ready handshake.
//  - Buffers up to 2 requests.
//  - Decodes each opcode into the shifter's one-hot-ish controls (SftR/SftA/SftL/SftC).
//  - Normalises out-of-range amounts so the shifter only sees legal amounts in 0..DATA_WIDTH-1.
//  - Drops illegal opcodes and counts them.

---
 rtl/zion_shift_req_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/zion_shift_req_stage.sv
// ============================================================================
// zion_shift_req_stage: 2-deep request FIFO that decodes and normalises shift requests
// Rev 1.0
// ============================================================================
`default_nettype none

module zion_shift_req_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iReqVld,
  output logic                  oReqRdy,
  input  logic [2:0]            iOp,
  input  logic [DATA_WIDTH-1:0] iDat,
  input  logic [AMT_WIDTH:0]    iAmt,
  output logic                  oVld,
  input  logic                  iRdy,
  output logic                  oSftR,
  output logic                  oSftA,
  output logic                  oSftL,
  output logic                  oSftC,
  output logic [DATA_WIDTH-1:0] oDat,
  output logic [AMT_WIDTH-1:0]  oSftBit,
  output logic                  oIllegal,
  output logic [CNT_WIDTH-1:0]  oIllCnt
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                  r;
    logic                  a;
    logic                  l;
    logic                  c;
    logic [DATA_WIDTH-1:0] dat;
    logic [AMT_WIDTH-1:0]  amt;
  } entryT;

  logic [1:0]           rCount;
  entryT                rHead;
  entryT                rTail;
  logic                 rIllegal;
  logic [CNT_WIDTH-1:0] rIllCnt;

  entryT wNew;
  logic  wAccept;
  logic  wIllOp;
  logic  wPush;
  logic  wPop;

  assign oReqRdy = rst_n && (rCount != 2'd2);
  assign oVld    = (rCount != 2'd0);
  assign wIllOp  = (iOp[2:1] == 2'b11);
  assign wAccept = iReqVld && oReqRdy;
  assign wPush   = wAccept && !wIllOp;
  assign wPop    = oVld && iRdy;

  // Decode once at write time; out-of-range non-rotate amounts collapse to
  // an equivalent legal request (zero result, or all sign bits for SRA).
  always_comb begin
    wNew     = '0;
    wNew.r   = (iOp[2:1] == 2'b00) || (iOp == 3'b100);
    wNew.l   = (iOp[2:1] == 2'b01) || (iOp == 3'b101);
    wNew.a   = !iOp[2] && iOp[0];
    wNew.c   = iOp[2];
    wNew.dat = iDat;
    wNew.amt = iAmt[AMT_WIDTH-1:0];
    if (!iOp[2] && iAmt[AMT_WIDTH]) begin
      if (iOp == 3'b001) begin
        wNew.amt = '1;
      end else begin
        wNew.dat = '0;
        wNew.amt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rCount   <= 2'd0;
      rHead    <= '0;
      rTail    <= '0;
      rIllegal <= 1'b0;
      rIllCnt  <= '0;
    end else begin
      rIllegal <= wAccept && wIllOp;
      if (wAccept && wIllOp && (rIllCnt != '1)) begin
        rIllCnt <= rIllCnt + C_CNT_ONE;
      end
      case ({wPush, wPop})
        2'b10: begin
          if (rCount == 2'd0) rHead <= wNew;
          else                rTail <= wNew;
          rCount <= rCount + 2'd1;
        end
        2'b01: begin
          rHead  <= rTail;
          rCount <= rCount - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; with a single entry the newcomer becomes head.
          if (rCount == 2'd1) begin
            rHead <= wNew;
          end else begin
            rHead <= rTail;
            rTail <= wNew;
          end
        end
        default: ;
      endcase
    end
  end

  assign oSftR    = oVld && rHead.r;
  assign oSftA    = oVld && rHead.a;
  assign oSftL    = oVld && rHead.l;
  assign oSftC    = oVld && rHead.c;
  assign oDat     = oVld ? rHead.dat : '0;
  assign oSftBit  = oVld ? rHead.amt : '0;
  assign oIllegal = rIllegal;
  assign oIllCnt  = rIllCnt;

endmodule

`default_nettype wire
